rr_arb4: RTL

//   4-requester round-robin arbiter with registered output. Drives the sel input of a
//   mux4 data selector. Shares one downstream valid/ready sink among four upstream

---
 rtl/arb_pkg.sv | 7 +
 rtl/mux4.sv | 25 ++
 rtl/rr_arb4.sv | 99 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_pkg;
    localparam int NREQ = 4;
    typedef logic [1:0] req_id_t;
endpackage

// File: rtl/mux4.sv
// Four-input data selector driven by the arbiter's grant index.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure datapath.
// Ports: sel (grant index), d0..d3 (candidate words), y (selected word).
module mux4
    import arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  req_id_t       sel,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [DW-1:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter sharing one registered valid/ready sink among four sources, with optional burst lock.
// Latency: 1 cycle from accepted input word to out_valid/out_data/out_id.
// Backpressure: in_ready only when the output register is empty or draining this cycle; a stall holds everything.
// Ports: clk, rst (sync active-high), in_valid[3:0], in_data0..3, in_ready[3:0],
//        out_valid, out_data, out_id, out_ready.
module rr_arb4
    import arb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int BURST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    in_valid,
    input  logic [DW-1:0] in_data0,
    input  logic [DW-1:0] in_data1,
    input  logic [DW-1:0] in_data2,
    input  logic [DW-1:0] in_data3,
    output logic [3:0]    in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output req_id_t       out_id,
    input  logic          out_ready
);
    localparam int            CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    req_id_t       ptr;
    req_id_t       sel;
    req_id_t       cand;
    logic          locked;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] new_cnt;
    logic          any_req;
    logic          hold_lock;
    logic          found;
    logic          load;
    logic          transfer;
    logic [DW-1:0] mux_dat;

    mux4 #(.DW(DW)) u_mux (
        .sel (sel),
        .d0  (in_data0),
        .d1  (in_data1),
        .d2  (in_data2),
        .d3  (in_data3),
        .y   (mux_dat)
    );

    always_comb begin
        any_req   = |in_valid;
        // The lock only holds while the owner keeps asserting valid.
        hold_lock = locked && in_valid[ptr];
        sel       = ptr;
        cand      = ptr;
        found     = 1'b0;
        if (!hold_lock) begin
            // Scan ptr+1, ptr+2, ... wrapping; i == NREQ revisits ptr itself last.
            for (int i = 1; i <= NREQ; i++) begin
                cand = ptr + req_id_t'(i);
                if (!found && in_valid[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end

        load     = !out_valid || out_ready;
        transfer = any_req && load && !rst;
        in_ready = transfer ? (4'b0001 << sel) : 4'b0000;

        // Burst counter saturates at BURST rather than wrapping.
        if (hold_lock) begin
            new_cnt = (burst_cnt == BURST_C) ? burst_cnt : burst_cnt + CW'(1);
        end else begin
            new_cnt = CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= 2'd3;
            burst_cnt <= '0;
            locked    <= 1'b0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_dat;
            out_id    <= sel;
            ptr       <= sel;
            burst_cnt <= new_cnt;
            locked    <= (new_cnt < BURST_C);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
